// File: rtl/sram_pkg.sv
// Shared constants, clear-FSM state type and byte-lane merge helper for sram_tdp_be.
package sram_pkg;

    localparam int unsigned RDW_READ_FIRST  = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;
    localparam int unsigned RDW_NO_CHANGE   = 2;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int unsigned MAX_DW = 256;
    localparam int unsigned MAX_BE = MAX_DW / 8;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

    // Take new_w bytes where be is set, old_w bytes elsewhere.
    function automatic logic [MAX_DW-1:0] be_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_BE-1:0] be);
        logic [MAX_DW-1:0] r;
        r = old_w;
        for (int i = 0; i < MAX_BE; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// Clear engine: walks the array one word per cycle writing a latched fill value.
module sram_clear_fsm
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned RAM_SIZE   = 65536,
    parameter int unsigned INIT_CLEAR = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr_req,
    input  logic [DATA_WIDTH-1:0] clr_value,
    output logic                  busy,
    output logic                  active_c,
    output logic                  clr_we_c,
    output logic [ADDR_WIDTH-1:0] clr_addr_c,
    output logic [DATA_WIDTH-1:0] clr_data_c
);

    // One extra bit so RAM_SIZE = 2^ADDR_WIDTH terminates without wrapping.
    localparam int unsigned CW = ADDR_WIDTH + 1;

    clr_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;
    logic                  init_q;

    // State, counter, fill value; busy lags the state by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
            val_q   <= '0;
            busy    <= 1'b0;
            init_q  <= (INIT_CLEAR != 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            busy    <= (state_q != CLR_IDLE);
            init_q  <= 1'b0;
        end
    end

    // Next state and the clear-write strobe into port A.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        val_d      = val_q;
        active_c   = (state_q != CLR_IDLE);
        clr_we_c   = (state_q == CLR_CLEAR);
        clr_addr_c = ADDR_WIDTH'(cnt_q);
        clr_data_c = val_q;
        case (state_q)
            CLR_IDLE: begin
                if (clr_req || init_q) begin
                    state_d = CLR_CLEAR;
                    cnt_d   = '0;
                    val_d   = clr_value;
                end
            end
            CLR_CLEAR: begin
                if (cnt_q == CW'(RAM_SIZE - 1)) state_d = CLR_DONE;
                else                            cnt_d   = cnt_q + CW'(1);
            end
            CLR_DONE: state_d = CLR_IDLE;
            default:  state_d = CLR_IDLE;
        endcase
    end

endmodule

// File: rtl/sram_tdp_be.sv
// True dual-port RAM with byte enables, RDW modes, A-priority collisions and a clear engine.
module sram_tdp_be
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned RAM_SIZE   = 65536,
    parameter string       FILE       = "images.mem",
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned INIT_CLEAR = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr_req,
    input  logic [DATA_WIDTH-1:0]   clr_value,
    output logic                    busy,
    input  logic                    a_en,
    input  logic                    a_we,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_rvalid,
    input  logic                    b_en,
    input  logic                    b_we,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned IW = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
    localparam int unsigned AW1 = ADDR_WIDTH + 1;

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

    logic                  active_c, clr_we_c;
    logic [ADDR_WIDTH-1:0] clr_addr_c;
    logic [DATA_WIDTH-1:0] clr_data_c;

    logic                  a_acc_c, a_wr_c, a_in_c;
    logic [ADDR_WIDTH-1:0] a_adr_c;
    logic [DATA_WIDTH-1:0] a_wd_c, a_old_c, a_new_c, a_rd_c;
    logic [NB-1:0]         a_be_c;
    logic [IW-1:0]         a_idx_c;
    logic                  b_acc_c, b_wr_c, b_in_c;
    logic [DATA_WIDTH-1:0] b_old_c, b_new_c, b_rd_c;
    logic [IW-1:0]         b_idx_c;

    sram_clear_fsm #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_SIZE   (RAM_SIZE),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clear (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_req    (clr_req),
        .clr_value  (clr_value),
        .busy       (busy),
        .active_c   (active_c),
        .clr_we_c   (clr_we_c),
        .clr_addr_c (clr_addr_c),
        .clr_data_c (clr_data_c)
    );

    // Port A datapath is shared with the clear engine; user accesses are dropped while it runs.
    assign a_acc_c = a_en & ~active_c;
    assign a_wr_c  = active_c ? clr_we_c   : (a_en & a_we);
    assign a_adr_c = active_c ? clr_addr_c : a_addr;
    assign a_wd_c  = active_c ? clr_data_c : a_wdata;
    assign a_be_c  = active_c ? {NB{1'b1}} : a_be;
    assign a_in_c  = ({1'b0, a_adr_c} < AW1'(RAM_SIZE));
    assign a_idx_c = IW'(a_adr_c);
    assign a_old_c = a_in_c ? mem[a_idx_c] : '0;
    assign a_new_c = DATA_WIDTH'(be_merge(MAX_DW'(a_old_c), MAX_DW'(a_wd_c), MAX_BE'(a_be_c)));

    assign b_acc_c = b_en & ~active_c;
    assign b_wr_c  = b_acc_c & b_we;
    assign b_in_c  = ({1'b0, b_addr} < AW1'(RAM_SIZE));
    assign b_idx_c = IW'(b_addr);
    assign b_old_c = b_in_c ? mem[b_idx_c] : '0;
    assign b_new_c = DATA_WIDTH'(be_merge(MAX_DW'(b_old_c), MAX_DW'(b_wdata), MAX_BE'(b_be)));

    // Per-lane writes; A is written last so it wins on bytes both ports enable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (b_wr_c && b_in_c && b_be[i]) mem[b_idx_c][8*i +: 8] <= b_wdata[8*i +: 8];
            if (a_wr_c && a_in_c && a_be_c[i]) mem[a_idx_c][8*i +: 8] <= a_wd_c[8*i +: 8];
        end
    end

    // Port A read-during-write selection.
    always_comb begin
        a_rd_c = a_old_c;
        if (a_we) begin
            case (RDW_MODE)
                RDW_NO_CHANGE:   a_rd_c = a_rdata;
                RDW_WRITE_FIRST: a_rd_c = a_in_c ? a_new_c : '0;
                RDW_READ_FIRST:  a_rd_c = a_old_c;
                default:         a_rd_c = a_old_c;
            endcase
        end
    end

    // Port B read-during-write selection.
    always_comb begin
        b_rd_c = b_old_c;
        if (b_we) begin
            case (RDW_MODE)
                RDW_NO_CHANGE:   b_rd_c = b_rdata;
                RDW_WRITE_FIRST: b_rd_c = b_in_c ? b_new_c : '0;
                RDW_READ_FIRST:  b_rd_c = b_old_c;
                default:         b_rd_c = b_old_c;
            endcase
        end
    end

    // Registered read data and one-cycle valid pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata  <= '0;
            a_rvalid <= 1'b0;
            b_rdata  <= '0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_acc_c;
            b_rvalid <= b_acc_c;
            if (a_acc_c) a_rdata <= a_rd_c;
            if (b_acc_c) b_rdata <= b_rd_c;
        end
    end

endmodule

// File: tb/tb_sram_tdp_be.sv
// Bench for sram_tdp_be: four instances (READ_FIRST, WRITE_FIRST, NO_CHANGE, small WRITE_FIRST)
// share one stimulus stream; a behavioural model feeds a per-cycle scoreboard.
module tb_sram_tdp_be;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clr_req;
    logic [31:0] clr_value;
    logic        a_en, a_we, b_en, b_we;
    logic [3:0]  a_be, a_addr, b_be, b_addr;
    logic [31:0] a_wdata, b_wdata;

    logic        busy_w [NI];
    logic        a_rvalid_w [NI];
    logic        b_rvalid_w [NI];
    logic [31:0] a_rdata_w [NI];
    logic [31:0] b_rdata_w [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sram_tdp_be #(
            .DATA_WIDTH (32),
            .ADDR_WIDTH (4),
            .RAM_SIZE   ((g == 3) ? 12 : 16),
            .FILE       (""),
            .RDW_MODE   ((g == 2) ? 2 : ((g == 0) ? 0 : 1)),
            .INIT_CLEAR (0)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .clr_req   (clr_req),
            .clr_value (clr_value),
            .busy      (busy_w[g]),
            .a_en      (a_en),
            .a_we      (a_we),
            .a_be      (a_be),
            .a_addr    (a_addr),
            .a_wdata   (a_wdata),
            .a_rdata   (a_rdata_w[g]),
            .a_rvalid  (a_rvalid_w[g]),
            .b_en      (b_en),
            .b_we      (b_we),
            .b_be      (b_be),
            .b_addr    (b_addr),
            .b_wdata   (b_wdata),
            .b_rdata   (b_rdata_w[g]),
            .b_rvalid  (b_rvalid_w[g])
        );
    end

    // Behavioural model state per instance.
    int          rs_m [NI]   = '{16, 16, 16, 12};
    int          mode_m [NI] = '{0, 1, 2, 1};
    logic [31:0] mem_m [NI][16];
    logic [31:0] ard_m [NI];
    logic [31:0] brd_m [NI];
    int          phase_m [NI];
    int          cnt_m [NI];
    logic [31:0] val_m [NI];

    typedef struct {
        logic        busy;
        logic        av;
        logic [31:0] ad;
        logic        bv;
        logic [31:0] bd;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        a_en;
        logic        a_we;
        logic [3:0]  a_be;
        logic [3:0]  a_addr;
        logic [31:0] a_wdata;
        logic        b_en;
        logic        b_we;
        logic [3:0]  b_be;
        logic [3:0]  b_addr;
        logic [31:0] b_wdata;
        int          chk_inst;
        logic        chk_b;
        logic [31:0] chk_val;
    } vec_t;
    vec_t vecs [15];

    int   total = 0;
    int   bad = 0;
    logic rd_chk = 1'b1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp_v);
        end
    endtask

    function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_m(input int i, input logic [3:0] ad);
        return (int'(ad) < rs_m[i]) ? mem_m[i][ad] : 32'h0;
    endfunction

    function automatic logic [31:0] port_rd(input int i, input logic we, input logic [3:0] ad,
                                            input logic [31:0] wd, input logic [3:0] be,
                                            input logic [31:0] hold);
        logic [31:0] old;
        old = rd_m(i, ad);
        if (!we) return old;
        if (mode_m[i] == 2) return hold;
        if (mode_m[i] == 1) return (int'(ad) < rs_m[i]) ? merge32(old, wd, be) : 32'h0;
        return old;
    endfunction

    // Predict every instance's outputs after the coming edge and advance the model.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            exp_t e;
            e.busy = (phase_m[i] != 0);
            e.av = 1'b0; e.ad = ard_m[i];
            e.bv = 1'b0; e.bd = brd_m[i];
            if (phase_m[i] == 0) begin
                if (a_en) begin e.av = 1'b1; e.ad = port_rd(i, a_we, a_addr, a_wdata, a_be, ard_m[i]); end
                if (b_en) begin e.bv = 1'b1; e.bd = port_rd(i, b_we, b_addr, b_wdata, b_be, brd_m[i]); end
                if (b_en && b_we && int'(b_addr) < rs_m[i])
                    mem_m[i][b_addr] = merge32(mem_m[i][b_addr], b_wdata, b_be);
                if (a_en && a_we && int'(a_addr) < rs_m[i])
                    mem_m[i][a_addr] = merge32(mem_m[i][a_addr], a_wdata, a_be);
                if (clr_req) begin phase_m[i] = 1; cnt_m[i] = 0; val_m[i] = clr_value; end
            end else if (phase_m[i] == 1) begin
                mem_m[i][4'(cnt_m[i])] = val_m[i];
                if (cnt_m[i] == rs_m[i] - 1) phase_m[i] = 2;
                else                         cnt_m[i]++;
            end else begin
                phase_m[i] = 0;
            end
            ard_m[i] = e.ad;
            brd_m[i] = e.bd;
            sbq.push_back(e);
        end
    endtask

    // One clock with the current inputs; scoreboard compares just after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            exp_t e;
            e = sbq.pop_front();
            check32($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'(e.busy));
            check32($sformatf("a_rvalid[%0d]", i), 32'(a_rvalid_w[i]), 32'(e.av));
            check32($sformatf("b_rvalid[%0d]", i), 32'(b_rvalid_w[i]), 32'(e.bv));
            if (rd_chk) begin
                check32($sformatf("a_rdata[%0d]", i), a_rdata_w[i], e.ad);
                check32($sformatf("b_rdata[%0d]", i), b_rdata_w[i], e.bd);
            end
        end
    endtask

    task automatic idle();
        a_en = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 4'h0; a_wdata = 32'h0;
        b_en = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = 4'h0; b_wdata = 32'h0;
        clr_req = 1'b0;
    endtask

    task automatic set_a(input logic we, input logic [3:0] be, input logic [3:0] ad, input logic [31:0] wd);
        a_en = 1'b1; a_we = we; a_be = be; a_addr = ad; a_wdata = wd;
    endtask

    task automatic set_b(input logic we, input logic [3:0] be, input logic [3:0] ad, input logic [31:0] wd);
        b_en = 1'b1; b_we = we; b_be = be; b_addr = ad; b_wdata = wd;
    endtask

    // Assert reset asynchronously, check outputs clear at once, release after an edge.
    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            ard_m[i] = 32'h0; brd_m[i] = 32'h0; phase_m[i] = 0; cnt_m[i] = 0;
            check32($sformatf("rst_busy[%0d]", i), 32'(busy_w[i]), 32'h0);
            check32($sformatf("rst_a_rvalid[%0d]", i), 32'(a_rvalid_w[i]), 32'h0);
            check32($sformatf("rst_b_rvalid[%0d]", i), 32'(b_rvalid_w[i]), 32'h0);
            check32($sformatf("rst_a_rdata[%0d]", i), a_rdata_w[i], 32'h0);
            check32($sformatf("rst_b_rdata[%0d]", i), b_rdata_w[i], 32'h0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Read every address on both ports; optionally compare instance 0 port A with a known fill.
    task automatic readback(input int mode, input logic [31:0] fill, input logic [31:0] base);
        for (int a = 0; a < 16; a++) begin
            idle();
            set_a(1'b0, 4'h0, 4'(a), 32'h0);
            set_b(1'b0, 4'h0, 4'(15 - a), 32'h0);
            step();
            if (mode == 1) check32($sformatf("fill[%0d]", a), a_rdata_w[0], fill);
            if (mode == 2) check32($sformatf("partial_fill[%0d]", a), a_rdata_w[0],
                                   (a < 6) ? fill : (base | 32'(a)));
        end
    endtask

    initial begin
        int busy_cnt;
        bit seen;
        idle();
        clr_value = 32'h0;
        reset_n = 1'b1;
        #2;
        do_reset();

        // Preload known contents; old words are unknown so rdata is not compared here.
        rd_chk = 1'b0;
        for (int a = 0; a < 8; a++) begin
            idle();
            set_a(1'b1, 4'hF, 4'(a), 32'hC0DE_0000 | 32'(a));
            set_b(1'b1, 4'hF, 4'(a + 8), 32'hC0DE_0000 | 32'(a + 8));
            step();
        end
        idle();
        set_a(1'b0, 4'h0, 4'd0, 32'h0);
        set_b(1'b0, 4'h0, 4'd8, 32'h0);
        rd_chk = 1'b1;
        step();

        vecs[0]  = '{1'b1, 1'b1, 4'hF, 4'd3,  32'h1122_3344, 1'b0, 1'b0, 4'h0, 4'd0,  32'h0,         -1, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 4'h5, 4'd3,  32'hAABB_CCDD, 1'b0, 1'b0, 4'h0, 4'd0,  32'h0,          1, 1'b0, 32'h11BB_33DD};
        vecs[2]  = '{1'b1, 1'b0, 4'h0, 4'd3,  32'h0,         1'b1, 1'b0, 4'h0, 4'd3,  32'h0,          0, 1'b0, 32'h11BB_33DD};
        vecs[3]  = '{1'b1, 1'b1, 4'hF, 4'd4,  32'h0000_0012, 1'b0, 1'b0, 4'h0, 4'd0,  32'h0,         -1, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 4'hF, 4'd4,  32'h0000_0055, 1'b0, 1'b0, 4'h0, 4'd0,  32'h0,          0, 1'b0, 32'h0000_0012};
        vecs[5]  = '{1'b1, 1'b0, 4'h0, 4'd4,  32'h0,         1'b1, 1'b0, 4'h0, 4'd4,  32'h0,          2, 1'b0, 32'h0000_0055};
        vecs[6]  = '{1'b1, 1'b0, 4'h0, 4'd7,  32'h0,         1'b1, 1'b1, 4'hF, 4'd7,  32'h0,          0, 1'b0, 32'hC0DE_0007};
        vecs[7]  = '{1'b1, 1'b1, 4'hF, 4'd5,  32'h0,         1'b1, 1'b0, 4'h0, 4'd7,  32'h0,          1, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 1'b1, 4'h1, 4'd5,  32'h0000_00FF, 1'b1, 1'b1, 4'h3, 4'd5,  32'h0000_AB00, -1, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 4'h0, 4'd5,  32'h0,         1'b1, 1'b0, 4'h0, 4'd5,  32'h0,          0, 1'b1, 32'h0000_ABFF};
        vecs[10] = '{1'b1, 1'b1, 4'h0, 4'd6,  32'hFFFF_FFFF, 1'b1, 1'b1, 4'h0, 4'd6,  32'hFFFF_FFFF, -1, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 4'h0, 4'd6,  32'h0,         1'b0, 1'b0, 4'h0, 4'd0,  32'h0,          1, 1'b0, 32'hC0DE_0006};
        vecs[12] = '{1'b1, 1'b1, 4'hF, 4'd13, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'h0, 4'd0,  32'h0,         -1, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 4'h0, 4'd13, 32'h0,         1'b1, 1'b0, 4'h0, 4'd13, 32'h0,          3, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 4'h0, 4'd13, 32'h0,         1'b0, 1'b0, 4'h0, 4'd0,  32'h0,          0, 1'b0, 32'hDEAD_BEEF};

        for (int v = 0; v < 15; v++) begin
            idle();
            a_en = vecs[v].a_en; a_we = vecs[v].a_we; a_be = vecs[v].a_be;
            a_addr = vecs[v].a_addr; a_wdata = vecs[v].a_wdata;
            b_en = vecs[v].b_en; b_we = vecs[v].b_we; b_be = vecs[v].b_be;
            b_addr = vecs[v].b_addr; b_wdata = vecs[v].b_wdata;
            step();
            if (vecs[v].chk_inst >= 0)
                check32($sformatf("vec%0d", v),
                        vecs[v].chk_b ? b_rdata_w[vecs[v].chk_inst] : a_rdata_w[vecs[v].chk_inst],
                        vecs[v].chk_val);
        end
        readback(0, 32'h0, 32'h0);

        // Full clear: reads during busy must be ignored; busy lasts RAM_SIZE+1 cycles.
        idle();
        clr_req = 1'b1;
        clr_value = 32'h0000_007E;
        step();
        busy_cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            idle();
            clr_req = (k == 3);
            clr_value = 32'h0000_0011;
            set_a(1'b0, 4'h0, 4'($urandom_range(0, 15)), 32'h0);
            set_b(1'b0, 4'h0, 4'($urandom_range(0, 15)), 32'h0);
            step();
            if (busy_w[0]) busy_cnt++;
            else if (busy_cnt > 0) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL clear_timeout: got busy_cnt=%0d want busy to fall", busy_cnt);
        end
        check32("busy_cycles", 32'(busy_cnt), 32'd17);
        readback(1, 32'h0000_007E, 32'h0);

        // Reset in the middle of a clear after six words have been filled.
        for (int a = 0; a < 16; a++) begin
            idle();
            set_a(1'b1, 4'hF, 4'(a), 32'h5A00_0000 | 32'(a));
            step();
        end
        idle();
        clr_req = 1'b1;
        clr_value = 32'h0000_007E;
        step();
        idle();
        for (int k = 0; k < 6; k++) step();
        do_reset();
        readback(2, 32'h0000_007E, 32'h5A00_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
